mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequencer for the memory-side registers of the CPU datapath: MAR, MDR and the MDMux select.
- Accepts single read/write requests from the control unit.
- Loads MAR from the bus, drives the external memory strobes, and waits for a memory-ready handshake with timeout.
- Loads MDR from memory (read) or from the bus (write).
- Gates MDR back onto the bus.
- Sits between the control unit and the MAR/MDR/memory interface.

Parameters:
TIMEOUT, 8, maximum cycles spent in MEM_REQ waiting for mem_ready before aborting (legal range 2..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  system clock, all state updates on rising edge
clear  in  1  asynchronous, active-low reset (0 = reset)
req_read  in  1  control unit requests a memory read; address is on BusMuxOut in the following cycle
req_write  in  1  control unit requests a memory write; address on bus next cycle, write data the cycle after
mem_ready  in  1  memory handshake: read data valid / write accepted
MARin  out  1  load MAR from bus
MDRin  out  1  load MDR
read  out  1  MDMux select: 1 = Mdatain, 0 = BusMuxOut
MDRout  out  1  drive MDR onto bus
wdata_en  out  1  control unit must drive write data onto the bus this cycle
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
timeout  out  1  one-cycle abort pulse

Behaviour:
- Moore machine; all outputs decode from the state register only. Reset forces state IDLE, counter 0, and every output 0.
- Reset mid-operation aborts immediately: strobes drop asynchronously and no done/timeout pulse is issued.
- States and outputs:
  - IDLE: all outputs 0.
  - LOAD_MAR: MARin=1.
  - LOAD_MDR (write only): MDRin=1, read=0, wdata_en=1.
  - MEM_REQ: mem_rd=1 (read) or mem_wr=1 (write), held steady for the whole state.
  - CAPTURE (read only): MDRin=1, read=1.
  - DONE: done=1; MDRout=1 for reads only.
  - ERR: timeout=1.
- Transitions:
  - IDLE -> LOAD_MAR when req_read or req_write is 1. A direction flag is latched at that edge.
  - Both requests high together: read wins, write is dropped.
  - Requests are ignored in every state except IDLE; no queuing.
  - LOAD_MAR -> LOAD_MDR (write) or MEM_REQ (read).
  - LOAD_MDR -> MEM_REQ.
  - MEM_REQ -> CAPTURE (read) or DONE (write) when mem_ready=1, including the first MEM_REQ cycle.
  - MEM_REQ -> ERR when mem_ready=0 and cnt == TIMEOUT-1.
  - MEM_REQ otherwise: stay, cnt++.
  - CAPTURE -> DONE.
  - DONE -> IDLE, and ERR -> IDLE, unconditionally.
- Wait counter: cleared on every entry to MEM_REQ, so MEM_REQ lasts at most TIMEOUT cycles. mem_ready arriving in the same cycle as cnt == TIMEOUT-1 counts as success; ready wins over timeout.
- mem_ready is ignored outside MEM_REQ. A stale high mem_ready on MEM_REQ entry is accepted as a handshake, so memory must deassert it between accesses.
- Latency with zero wait states, counting edges after the request is sampled in IDLE:
  - Read: DONE on the 4th edge (IDLE, LOAD_MAR, MEM_REQ, CAPTURE, DONE).
  - Write: DONE on the 4th edge (IDLE, LOAD_MAR, LOAD_MDR, MEM_REQ, DONE).
  - Each memory wait cycle adds 1.
- A new request may be sampled in the cycle after DONE or ERR, when the machine is back in IDLE.
- MARin, MDRin and MDRout are never high in the same cycle. mem_rd and mem_wr are never both high.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD_MAR, LOAD_MDR, MEM_REQ, CAPTURE, DONE, ERR; 3-bit binary);
  - the direction flag encoding;
  - the default TIMEOUT constant.
- One natural sub-module, wait_timer: load-zero/increment counter with a terminal-count compare, parameterised by TIMEOUT and CNT_W.

Test Plan:
- Reset: hold clear=0 with req_read=1 for 3 cycles -> all outputs 0, busy=0; release clear -> IDLE samples req_read on the next edge.
- Read, zero wait: pulse req_read with mem_ready tied 1 -> MARin, mem_rd, MDRin+read, then done+MDRout, each on its own single cycle, 4 edges total; MDR captures Mdatain=32'hDEADBEEF.
- Write, 3 waits: pulse req_write, bus 32'h0000_0040 then 32'h1234_5678, mem_ready high on the 4th MEM_REQ cycle -> mem_wr high for exactly 4 cycles, done 7 edges after the request, MDRin with read=0 only in LOAD_MDR.
- Timeout with TIMEOUT=4: req_read, mem_ready held 0 -> mem_rd high for exactly 4 cycles, one timeout pulse, no done, IDLE on the next edge.
- Boundary/priority: req_read and req_write both high -> read sequence only. Mid-sequence requests ignored. mem_ready on the 4th MEM_REQ cycle with TIMEOUT=4 -> done, no timeout.
- Async abort: assert clear=0 mid-edge during MEM_REQ -> mem_rd and busy drop without a clock edge; no done or timeout after release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state/direction encodings and defaults for the memory-side sequencer
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAR = 3'd1,
    S_LOAD_MDR = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_e;
  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;
  localparam int TIMEOUT_DEF = 8;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: cycle counter for MEM_REQ with terminal-count compare at TIMEOUT-1
//   clock_i/clear_i : clock, async active-low reset
//   clr_i           : load zero (held while outside MEM_REQ)
//   inc_i           : count one cycle
//   tc_o            : count has reached TIMEOUT-1
module wait_timer #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic clock_i,
  input  logic clear_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clock_i or negedge clear_i)
    if (!clear_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign tc_o = cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Moore sequencer for MAR/MDR/MDMux and memory strobes with ready timeout
//   clock_i, clear_i (async active-low)      : clock and reset
//   req_read_i, req_write_i, mem_ready_i     : control-unit requests, memory handshake
//   MARin_o, MDRin_o, read_o, MDRout_o       : datapath register controls / MDMux select
//   wdata_en_o, mem_rd_o, mem_wr_o           : write-data enable, memory strobes
//   busy_o, done_o, timeout_o                : status and one-cycle completion/abort pulses
module mem_access_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic clock_i,
  input  logic clear_i,
  input  logic req_read_i,
  input  logic req_write_i,
  input  logic mem_ready_i,
  output logic MARin_o,
  output logic MDRin_o,
  output logic read_o,
  output logic MDRout_o,
  output logic wdata_en_o,
  output logic mem_rd_o,
  output logic mem_wr_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);
  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  logic   tc;
  logic   rd;
  // counter sits at zero outside MEM_REQ, so every entry starts a fresh wait window
  wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clock_i(clock_i),
    .clear_i(clear_i),
    .clr_i  (state_q != S_MEM_REQ),
    .inc_i  (1'b1),
    .tc_o   (tc)
  );
  always_ff @(posedge clock_i or negedge clear_i)
    if (!clear_i) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_WR;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  assign rd = dir_q == DIR_RD;
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE:
        if (req_read_i || req_write_i) begin
          state_d = S_LOAD_MAR;
          dir_d   = req_read_i ? DIR_RD : DIR_WR;
        end
      S_LOAD_MAR: state_d = rd ? S_MEM_REQ : S_LOAD_MDR;
      S_LOAD_MDR: state_d = S_MEM_REQ;
      // ready takes priority over the terminal count
      S_MEM_REQ:  state_d = mem_ready_i ? (rd ? S_CAPTURE : S_DONE) : tc ? S_ERR : S_MEM_REQ;
      S_CAPTURE:  state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end
  always_comb begin
    MARin_o    = state_q == S_LOAD_MAR;
    MDRin_o    = state_q == S_LOAD_MDR || state_q == S_CAPTURE;
    read_o     = state_q == S_CAPTURE;
    MDRout_o   = state_q == S_DONE && rd;
    wdata_en_o = state_q == S_LOAD_MDR;
    mem_rd_o   = state_q == S_MEM_REQ && rd;
    mem_wr_o   = state_q == S_MEM_REQ && !rd;
    busy_o     = state_q != S_IDLE;
    done_o     = state_q == S_DONE;
    timeout_o  = state_q == S_ERR;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven and randomized transaction checks for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int T = 4;
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_MAR   = 10'b1000000100;
  localparam logic [9:0] V_LMDR  = 10'b0100100100;
  localparam logic [9:0] V_MRD   = 10'b0000010100;
  localparam logic [9:0] V_MWR   = 10'b0000001100;
  localparam logic [9:0] V_CAP   = 10'b0110000100;
  localparam logic [9:0] V_DONER = 10'b0001000110;
  localparam logic [9:0] V_DONEW = 10'b0000000110;
  localparam logic [9:0] V_ERR   = 10'b0000000101;
  logic clk = 0, clear = 0, req_read = 0, req_write = 0, mem_ready = 0;
  logic mar_in, mdr_in, rd_sel, mdr_out, wen, mrd, mwr, busy, done, tout;
  logic [9:0] o;
  logic [31:0] bus, mdatain, mar, mdr;
  int n = 0, errs = 0, ecnt = 0, hit = 0;
  logic hd = 0;
  mem_access_ctrl #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clock_i(clk), .clear_i(clear), .req_read_i(req_read), .req_write_i(req_write),
    .mem_ready_i(mem_ready), .MARin_o(mar_in), .MDRin_o(mdr_in), .read_o(rd_sel),
    .MDRout_o(mdr_out), .wdata_en_o(wen), .mem_rd_o(mrd), .mem_wr_o(mwr),
    .busy_o(busy), .done_o(done), .timeout_o(tout)
  );
  assign o = {mar_in, mdr_in, rd_sel, mdr_out, wen, mrd, mwr, busy, done, tout};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mar_in) mar <= bus;
    if (mdr_in) mdr <= rd_sel ? mdatain : bus;
  end
  typedef struct {
    logic rr; logic ww; int w; logic [31:0] addr; logic [31:0] data; logic [31:0] md;
    logic exp_done; int exp_lat;
  } vec_t;
  vec_t tbl[7];
  task automatic step();
    @(posedge clk); #1;
    ecnt++;
    if ((done || tout) && hit == 0) begin hit = ecnt; hd = done; end
  endtask
  task automatic chk(input string nm, input logic [9:0] exp);
    n++;
    if (o !== exp) begin errs++; $display("FAIL %s: outputs %b, expected %b", nm, o, exp); end
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %h, expected %h", nm, act, exp); end
  endtask
  task automatic chk_int(input string nm, input int act, input int exp);
    n++;
    if (act != exp) begin errs++; $display("FAIL %s: got %0d, expected %0d", nm, act, exp); end
  endtask
  // one transaction from IDLE back to IDLE; w = MEM_REQ cycle index where ready is given
  task automatic run_txn(input logic rr, input logic ww, input int w,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] md);
    logic isrd;
    int k;
    logic ok;
    isrd = rr;
    ecnt = 0; hit = 0; hd = 0;
    mdatain = md;
    req_read = rr; req_write = ww; mem_ready = 1'($urandom);
    step();
    chk("load_mar", V_MAR);
    req_read = 1'($urandom); req_write = 1'($urandom); bus = addr; mem_ready = 1'($urandom);
    if (!isrd) begin
      step();
      chk("load_mdr", V_LMDR);
      bus = data; mem_ready = 1'($urandom);
    end
    step();
    bus = $urandom;
    k = 0; ok = 0;
    while (1) begin
      chk("mem_req", isrd ? V_MRD : V_MWR);
      mem_ready = (k == w);
      req_read = 1'($urandom); req_write = 1'($urandom);
      step();
      if (k == w) begin ok = 1; break; end
      if (k == T - 1) break;
      k++;
    end
    mem_ready = 1'($urandom);
    if (ok) begin
      if (isrd) begin chk("capture", V_CAP); step(); end
      chk("done", isrd ? V_DONER : V_DONEW);
      chk32("mar", mar, addr);
      chk32("mdr", mdr, isrd ? md : data);
    end else chk("err", V_ERR);
    req_read = 1'($urandom); req_write = 1'($urandom);
    step();
    chk("back_idle", V_IDLE);
    req_read = 0; req_write = 0; mem_ready = 0;
  endtask
  initial begin
    bus = 0; mdatain = 0;
    tbl[0] = '{1, 0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 4};
    tbl[1] = '{0, 1, 3, 32'h0000_0040, 32'h1234_5678, 32'h0, 1, 7};
    tbl[2] = '{1, 0, 9, 32'h0000_0080, 32'h0, 32'h1111_1111, 0, 6};
    tbl[3] = '{1, 1, 0, 32'h0000_00C0, 32'hBAD0_BAD0, 32'hCAFE_F00D, 1, 4};
    tbl[4] = '{1, 0, 3, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 1, 7};
    tbl[5] = '{0, 1, 0, 32'h0000_0140, 32'h8765_4321, 32'h0, 1, 4};
    tbl[6] = '{0, 1, 9, 32'h0000_0180, 32'hFFFF_0000, 32'h0, 0, 7};
    req_read = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("reset_hold", V_IDLE); end
    @(negedge clk); clear = 1;
    step(); chk("post_reset_read", V_MAR);
    req_read = 0; mem_ready = 0;
    step(); chk("abort_mem_req", V_MRD);
    #3 clear = 0;
    #1 chk("async_abort", V_IDLE);
    mem_ready = 1;
    @(negedge clk); clear = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("after_abort", V_IDLE); end
    mem_ready = 0;
    foreach (tbl[i]) begin
      run_txn(tbl[i].rr, tbl[i].ww, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].md);
      chk_int("tbl_done", int'(hd), int'(tbl[i].exp_done));
      chk_int("tbl_latency", hit, tbl[i].exp_lat);
    end
    for (int i = 0; i < 200; i++) begin
      logic rr, ww, isrd, succ;
      int w, gap, lat;
      rr = 1'($urandom); ww = 1'($urandom);
      if (!rr && !ww) ww = 1;
      isrd = rr;
      w = $urandom_range(0, 6);
      succ = w < T;
      lat = 1 + (isrd ? 0 : 1) + (succ ? w + 1 : T) + (succ ? (isrd ? 2 : 1) : 1);
      run_txn(rr, ww, w, $urandom, $urandom, $urandom);
      chk_int("rnd_done", int'(hd), int'(succ));
      chk_int("rnd_latency", hit, lat);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ready = 1'($urandom);
        step(); chk("rnd_idle", V_IDLE);
      end
      mem_ready = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
